// File: rtl/usb_fifo_arbiter.sv
// usb_fifo_arbiter: CY7C68013 slave-FIFO scheduler sharing one 16-bit port between EP2 reads and EP6 writes.
// Optional macro PKTEND_EN: a WR word flagged tx_last ends the burst with a one-cycle pktend pulse.
module usb_fifo_arbiter #(
  parameter int BURST_MAX = 256,
  parameter int TURN_CYC  = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        flaga,
  input  logic        flagd,
  input  logic [15:0] fdata_in,
  output logic [15:0] fdata_out,
  output logic        fdata_oe,
  output logic [1:0]  faddr,
  output logic        slrd,
  output logic        slwr,
  output logic        sloe,
  output logic        pktend,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic [3:0]  gstate
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam int TW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);
  localparam logic [TW-1:0] TURN_LAST  = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP6 = 2'b10;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    TURN = 4'b0010,
    RD   = 4'b0100,
    WR   = 4'b1000,
    PEND = 4'b1001
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      faddr_nxt;
  logic [1:0]      tgt;
  logic [CW-1:0]   burst_cnt;
  logic [TW-1:0]   turn_cnt;
  logic            last_rx;
  logic            rx_req, tx_req;
  logic            rd_stb, wr_stb;
  logic            burst_end;
  logic            pkt_end;
  logic            enter_burst;

  always_comb begin
    rx_req    = flaga & rx_ready;
    tx_req    = flagd & tx_valid;
    rd_stb    = (state == RD) & rx_req;
    wr_stb    = (state == WR) & tx_req;
    burst_end = (burst_cnt == BURST_LAST);
  end

`ifdef PKTEND_EN
  assign pkt_end = wr_stb & tx_last;
`else
  logic unused_tx_last;
  assign unused_tx_last = tx_last;
  assign pkt_end        = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    faddr_nxt   = faddr;
    tgt         = EP2;
    enter_burst = 1'b0;
    case (state)
      IDLE: begin
        if (rx_req | tx_req) begin
          // On contention the side that did not win last time takes the bus.
          tgt       = (rx_req & (~tx_req | ~last_rx)) ? EP2 : EP6;
          faddr_nxt = tgt;
          if ((tgt != faddr) && (TURN_CYC > 0)) begin
            state_nxt = TURN;
          end else begin
            state_nxt   = (tgt == EP2) ? RD : WR;
            enter_burst = 1'b1;
          end
        end
      end
      TURN: begin
        if (turn_cnt == TURN_LAST) begin
          state_nxt   = (faddr == EP2) ? RD : WR;
          enter_burst = 1'b1;
        end
      end
      RD: begin
        if (!rd_stb || burst_end) state_nxt = IDLE;
      end
      WR: begin
        if (pkt_end)                   state_nxt = PEND;
        else if (!wr_stb || burst_end) state_nxt = IDLE;
      end
      PEND:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    slrd      = ~rd_stb;
    sloe      = ~(state == RD);
    slwr      = ~wr_stb;
    fdata_oe  = (state == WR);
    tx_ready  = (state == WR) & flagd;
    fdata_out = (state == WR) ? tx_data : '0;
    pktend    = ~(state == PEND);
    gstate    = state;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      faddr     <= EP2;
      burst_cnt <= '0;
      turn_cnt  <= '0;
      last_rx   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      faddr    <= faddr_nxt;
      turn_cnt <= (state == TURN) ? turn_cnt + 1'b1 : '0;
      if (enter_burst) begin
        burst_cnt <= '0;
        last_rx   <= (state_nxt == RD);
      end else if (rd_stb | wr_stb) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      rx_valid <= rd_stb;
      if (rd_stb) rx_data <= fdata_in;
    end
  end

endmodule

// File: doc/usb_fifo_arbiter.md
# usb_fifo_arbiter

Scheduler for the CY7C68013 slave-FIFO bus. It shares the single 16-bit FIFO port between an RX path (EP2, PC->FPGA reads) and a TX path (EP6, FPGA->PC writes). It selects the endpoint, inserts bus turnaround, runs bounded bursts with round-robin fairness, and drives slrd/slwr/sloe/faddr/pktend. It sits between the FX2 pads and the FPGA-side stream producer and consumer.

## Interface
Parameters:
- BURST_MAX, 256, maximum strobes per grant (>=1)
- TURN_CYC, 2, idle cycles inserted when faddr changes (0 = none)

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flaga  in  1  EP2 empty flag, active low (1 = data present)
- flagd  in  1  EP6 full flag, active low (1 = space present)
- fdata_in  in  16  FIFO data from pads
- fdata_out  out  16  FIFO data to pads
- fdata_oe  out  1  pad output enable
- faddr  out  2  FIFO select: 2'b00 = EP2, 2'b10 = EP6
- slrd, slwr, sloe, pktend  out  1  FX2 strobes, active low
- rx_data  out  16  captured EP2 word
- rx_valid  out  1  rx_data valid, one-cycle pulse per word
- rx_ready  in  1  consumer has room for >=2 words
- tx_data  in  16  EP6 word
- tx_valid  in  1  tx_data valid
- tx_last  in  1  word ends a packet (used only with PKTEND_EN)
- tx_ready  out  1  word accepted when tx_valid & tx_ready
- gstate  out  4  debug state code

## Operation
- States: IDLE (gstate 0001), TURN (0010), RD (0100), WR (1000), PEND (1001).
- Requests are evaluated in IDLE: rx_req = flaga & rx_ready; tx_req = flagd & tx_valid.
- Single request: grant that side. Both requesting: grant the side not granted last (last_grant register; reset value TX, so RX wins first). No request: stay in IDLE.
- On grant, faddr loads the target endpoint. If the target differs from the current faddr and TURN_CYC>0, go to TURN for TURN_CYC cycles, then RD or WR. Otherwise go directly to RD or WR.
- Entering RD or WR clears burst_cnt (width clog2(BURST_MAX+1)) and updates last_grant.
- RD behaviour:
  - sloe=0 for the whole state.
  - slrd = ~(flaga & rx_ready), combinational.
  - Each edge with slrd=0 captures fdata_in into rx_data, and rx_valid=1 on the next cycle. A word is never dropped.
  - Exit to IDLE when flaga=0, rx_ready=0, or the BURST_MAX-th strobe has issued.
- WR behaviour:
  - fdata_oe=1; fdata_out = tx_data.
  - slwr = ~(flagd & tx_valid); tx_ready = flagd (combinational).
  - Exit when flagd=0, tx_valid=0, or the BURST_MAX-th strobe has issued. Destination is PEND or IDLE (see Configuration).
- Outside RD: sloe=1, slrd=1. Outside WR: slwr=1, fdata_oe=0, tx_ready=0.
- Never both RD and WR strobes in one cycle. fdata_oe and sloe=0 are never simultaneously asserted.

## Timing
- Reset values: faddr=00, slrd=slwr=sloe=pktend=1, fdata_oe=0, rx_valid=0, rx_data=0, tx_ready=0, gstate=0001, state IDLE, last_grant=TX.
- Grant latency, IDLE with request to first strobe: 1 cycle when faddr is unchanged, 1+TURN_CYC cycles otherwise.
- Throughput: one word per cycle inside a burst.
- RX latency: strobe edge to rx_valid is 1 cycle.
- The burst limit takes priority over flags. The cycle after the BURST_MAX-th strobe is IDLE even if data remains. The other side is then granted if it is requesting.
- A flag dropping mid-burst suppresses the strobe in that same cycle.
- Reset mid-burst forces every output to its reset value asynchronously. No partial strobe remains after rst_n is released.

## Configuration
- PKTEND_EN defined:
  - If the last accepted WR word had tx_last=1, WR exits to PEND.
  - PEND drives pktend=0 for exactly one cycle with faddr=10, then goes to IDLE.
  - tx_last on any other accepted word does not end the burst early.
- PKTEND_EN undefined: tx_last is ignored, pktend is constantly 1, and PEND is unreachable.

## Test plan
- Reset: hold rst_n=0 mid-WR burst -> all outputs at their reset values immediately; after release, first RX grant occurs with faddr=00.
- RX only: flaga=1 with 10 words queued, rx_ready=1 -> slrd=0 for 10 cycles, 10 rx_valid pulses in order matching fdata_in, return to IDLE.
- TX burst limit: BURST_MAX=4, tx_valid held 1, flagd=1 -> exactly 4 slwr pulses per grant, IDLE cycle between grants, and faddr stays 10 with no TURN.
- Contention: flaga=1 and flagd=1 continuously with tx_valid=1 -> grants alternate RD, WR, RD; each switch has TURN_CYC=2 idle cycles, and sloe=0 never overlaps fdata_oe=1.
- Backpressure: drop flagd for 3 cycles mid-burst -> slwr=1 and tx_ready=0 in those cycles, burst exits, and no word is lost or duplicated.
- PKTEND_EN: send 5 words with tx_last on the 5th -> one pktend=0 pulse the cycle after the 5th slwr; without the macro, pktend stays 1.
